instruction_memory_agent: RTL and testbench

Avalon-MM read agent that serves 32-bit instruction words from an on-chip memory array to the core's instruction fetch host. It accepts pipelined reads with a fixed response latency, bounds the number of outstanding reads, and applies back-pressure through `waitrequest`. A side write port lets the testbench or boot loader fill the array before execution.

---
 rtl/instruction_memory_agent_if.sv | 20 ++
 rtl/instruction_memory_agent.sv | 141 ++++++++++++++
 tb/tb_instruction_memory_agent.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_agent_if.sv
// Avalon-MM read-only bus between an instruction-fetch host and a memory agent.
// The host drives requests and the agent answers with fixed-latency read data.
interface AvalonMmRead;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic        readdatavalid;
    logic [31:0] agent_to_host;

    modport Agent (
        input  address, read, byteenable,
        output waitrequest, readdatavalid, agent_to_host
    );

    modport Host (
        output address, read, byteenable,
        input  waitrequest, readdatavalid, agent_to_host
    );
endinterface

// File: rtl/instruction_memory_agent.sv
// Instruction memory agent: serves pipelined fixed-latency Avalon-MM reads from a block RAM
// and has a side write port for loading the image before execution.
module instruction_memory_agent #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int MAX_PENDING = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    AvalonMmRead.Agent                     bus,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
    input  logic [31:0]                    wr_data,
    output logic                           fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    genvar gi;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      ram_q;
    logic             s0_valid_q;
    logic [3:0]       s0_be_q;
    logic             s0_oor_q;
    logic [3:0][7:0]  s0_bytes;
    logic [31:0]      s0_word;
    logic [PW-1:0]    pending_q;
    logic [PW-1:0]    pending_d;
    logic             fault_q;
    logic             accept;
    logic             req_oor;
    logic [AW-1:0]    req_idx;
    logic             wait_w;
    logic             rdv;
    logic [31:0]      a2h;
    logic             unused_addr_bits;

    assign req_idx          = bus.address[AW+1:2];
    assign req_oor          = |bus.address[31:AW+2];
    assign unused_addr_bits = ^bus.address[1:0];

    // A slot frees in the same cycle its response is presented, so the host is not stalled then.
    assign wait_w = (pending_q == PW'(MAX_PENDING)) && !rdv;
    assign accept = bus.read && !wait_w && !rst;

    // Nonblocking write and read give read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (accept) begin
            ram_q <= mem[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_be_q    <= 4'h0;
            s0_oor_q   <= 1'b0;
        end else begin
            s0_valid_q <= accept;
            if (accept) begin
                s0_be_q  <= bus.byteenable;
                s0_oor_q <= req_oor;
            end
        end
    end

    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign s0_bytes[gi] = s0_be_q[gi] ? ram_q[8*gi +: 8] : 8'h00;
    end

    assign s0_word = s0_oor_q ? NOP_WORD : s0_bytes;

    always_comb begin
        pending_d = pending_q;
        case ({accept, rdv})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept && req_oor) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Stage 0 is the RAM output register; the remaining LATENCY-1 stages only shift.
    if (LATENCY == 1) begin : g_lat1
        assign rdv = s0_valid_q;
        assign a2h = s0_word;
    end else begin : g_tail
        logic        tail_valid_q [LATENCY-1];
        logic [31:0] tail_data_q  [LATENCY-1];

        for (gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
            logic        in_valid;
            logic [31:0] in_data;

            if (gi == 0) begin : g_first
                assign in_valid = s0_valid_q;
                assign in_data  = s0_word;
            end else begin : g_next
                assign in_valid = tail_valid_q[gi-1];
                assign in_data  = tail_data_q[gi-1];
            end

            // Data only moves with a valid beat, so the output holds between responses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    tail_valid_q[gi] <= 1'b0;
                    tail_data_q[gi]  <= 32'h0;
                end else begin
                    tail_valid_q[gi] <= in_valid;
                    if (in_valid) begin
                        tail_data_q[gi] <= in_data;
                    end
                end
            end
        end

        assign rdv = tail_valid_q[LATENCY-2];
        assign a2h = tail_data_q[LATENCY-2];
    end

    assign bus.waitrequest   = wait_w;
    assign bus.readdatavalid = rdv;
    assign bus.agent_to_host = a2h;
    assign fault             = fault_q;
endmodule

// File: tb/tb_instruction_memory_agent.sv
// Bench for instruction_memory_agent: directed scenarios plus random traffic, checked every
// cycle against a response-queue model of the memory, latency, pending limit and fault flag.
module tb_instruction_memory_agent;
    localparam int unsigned DEPTH = 1024;
    localparam int          AW    = 10;
    localparam int          LAT   = 3;
    localparam int          MP    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          fault;

    AvalonMmRead bus_if ();

    instruction_memory_agent #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .MAX_PENDING (MP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       exp_q [$];
    logic [31:0] mem_model [DEPTH];
    logic [31:0] last_data;
    logic        fault_m;
    logic        exp_wait;
    int          cyc;
    int          n_checks;
    int          n_pass;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [3:0] be);
        int unsigned idx;
        logic [31:0] mask;
        idx = addr >> 2;
        if (idx >= DEPTH) begin
            return 32'h0000_0013;
        end
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return mem_model[idx[AW-1:0]] & mask;
    endfunction

    // Called just after a falling edge: check this cycle's outputs, then drive the next request.
    task automatic cycle(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                         input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic r, output logic acc);
        logic        exp_rdv;
        int unsigned idx;
        exp_rdv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (exp_rdv) begin
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        exp_wait = (exp_q.size() >= MP);
        check_eq("readdatavalid", {31'b0, bus_if.readdatavalid}, {31'b0, exp_rdv});
        check_eq("agent_to_host", bus_if.agent_to_host, last_data);
        check_eq("waitrequest", {31'b0, bus_if.waitrequest}, {31'b0, exp_wait});
        check_eq("fault", {31'b0, fault}, {31'b0, fault_m});

        bus_if.read       = rd;
        bus_if.address    = addr;
        bus_if.byteenable = be;
        wr_en             = we;
        wr_addr           = wa;
        wr_data           = wd;
        rst               = r;

        acc = rd && !exp_wait && !r;
        if (r) begin
            exp_q.delete();
            fault_m   = 1'b0;
            last_data = 32'h0;
        end else if (acc) begin
            exp_q.push_back('{data: model_read(addr, be), due: cyc + LAT});
            idx = addr >> 2;
            if (idx >= DEPTH) begin
                fault_m = 1'b1;
            end
        end
        if (we) begin
            mem_model[wa] = wd;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cycle(1'b0, 32'h0, 4'h0, 1'b0, '0, 32'h0, 1'b0, a);
    endtask

    task automatic write_word(input logic [AW-1:0] idx, input logic [31:0] data);
        logic a;
        cycle(1'b0, 32'h0, 4'h0, 1'b1, idx, data, 1'b0, a);
    endtask

    // Holds the request until the agent takes it, as an Avalon host must.
    task automatic read_word(input logic [31:0] addr, input logic [3:0] be);
        logic a;
        for (int k = 0; k < 4 * LAT; k++) begin
            cycle(1'b1, addr, be, 1'b0, '0, 32'h0, 1'b0, a);
            if (a) begin
                return;
            end
        end
    endtask

    initial begin
        logic a;
        cyc       = 0;
        n_checks  = 0;
        n_pass    = 0;
        last_data = 32'h0;
        fault_m   = 1'b0;
        exp_wait  = 1'b0;
        rst               = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = 32'h0;
        bus_if.byteenable = 4'hF;
        wr_en             = 1'b0;
        wr_addr           = '0;
        wr_data           = 32'h0;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);

        // Second reset cycle with a read pending, then a quiet window.
        cycle(1'b1, 32'h0, 4'hF, 1'b0, '0, 32'h0, 1'b1, a);
        idle(10);

        for (int i = 0; i < int'(DEPTH); i++) begin
            write_word(AW'(i), $urandom);
        end

        // Single read.
        write_word(AW'(4), 32'h0050_0093);
        read_word(32'h10, 4'hF);
        idle(LAT + 2);

        // Back-to-back reads against the pending limit.
        write_word(AW'(0), 32'h11);
        write_word(AW'(1), 32'h22);
        write_word(AW'(2), 32'h33);
        read_word(32'h0, 4'hF);
        read_word(32'h4, 4'hF);
        read_word(32'h8, 4'hF);
        idle(LAT + 2);

        // Byte lanes.
        write_word(AW'(8), 32'hAABB_CCDD);
        read_word(32'h20, 4'b0011);
        read_word(32'h20, 4'b1000);
        read_word(32'h23, 4'b0110);
        idle(LAT + 2);

        // Range boundary and the sticky fault.
        read_word(32'h0000_0FFC, 4'hF);
        idle(LAT + 2);
        read_word(32'h0000_1000, 4'hF);
        idle(LAT + 4);

        // Read and write of the same word in the same cycle.
        write_word(AW'(5), 32'h7);
        cycle(1'b1, 32'h14, 4'hF, 1'b1, AW'(5), 32'h1, 1'b0, a);
        idle(LAT + 2);
        read_word(32'h14, 4'hF);
        idle(LAT + 2);

        // Reset with a read in flight.
        read_word(32'h10, 4'hF);
        cycle(1'b0, 32'h0, 4'h0, 1'b0, '0, 32'h0, 1'b1, a);
        idle(LAT + 2);
        read_word(32'h10, 4'hF);
        idle(LAT + 2);

        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        rd;
            logic        we;
            logic [31:0] addr;
            r  = ($urandom_range(0, 249) == 0);
            rd = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 9) == 0) begin
                addr = $urandom;
            end else begin
                addr = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
            end
            we = !r && ($urandom_range(0, 99) < 30);
            cycle(rd, addr, 4'($urandom), we, AW'($urandom), $urandom, r, a);
        end
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
